// File: rtl/uart_rx_fifo_if.sv
// Byte handshake bundle between the UART receiver, the rx FIFO and its consumer.
// master = receiver/consumer side, slave = FIFO side.
interface uart_rx_fifo_if;
    logic [7:0] in_data;
    logic       in_req;
    logic [7:0] out_data;
    logic       out_req;
    logic       out_ack;

    modport master (
        output in_data,
        output in_req,
        output out_ack,
        input  out_data,
        input  out_req
    );

    modport slave (
        input  in_data,
        input  in_req,
        input  out_ack,
        output out_data,
        output out_req
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO behind the UART receiver: strobe capture, req/ack drain, sticky overflow.
// Optional end-of-line counter enabled by defining UART_RX_FIFO_LINE_EN.
module uart_rx_fifo #(
    parameter int         AW  = 4,
    parameter logic [7:0] EOL = 8'h0A
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_fifo_if.slave bus,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic [AW:0]   line_cnt,
    output logic          line_rdy
);

    localparam int DEPTH = 2 ** AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] next_rd;
    logic [AW:0]   level_next;
    logic [7:0]    head_next;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    assign full        = (level == (AW+1)'(DEPTH));
    assign pop         = bus.out_ack & bus.out_req;
    assign push        = bus.in_req & (~full | pop);
    assign drop        = bus.in_req & ~push;
    assign bus.out_req = (level != '0);
    assign next_rd     = rd_ptr + AW'(pop);

    // Head for the next cycle; a byte written into an empty slot at the head bypasses memory.
    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
        head_next = mem[next_rd];
        if (push && (wr_ptr == next_rd))
            head_next = bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            bus.out_data <= 8'h00;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= next_rd;
            level  <= level_next;
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            // When the FIFO goes empty the last head value is simply held.
            if (level_next != '0)
                bus.out_data <= head_next;
        end
    end

`ifdef UART_RX_FIFO_LINE_EN
    logic eol_in;
    logic eol_out;

    assign eol_in   = push & (bus.in_data == EOL);
    assign eol_out  = pop & (bus.out_data == EOL);
    assign line_rdy = (line_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt <= '0;
        end else begin
            case ({eol_in, eol_out})
                2'b10:   line_cnt <= line_cnt + 1'b1;
                2'b01:   line_cnt <= line_cnt - 1'b1;
                default: line_cnt <= line_cnt;
            endcase
        end
    end
`else
    logic unused_eol;

    assign unused_eol = ^EOL;
    assign line_cnt   = '0;
    assign line_rdy   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a random soak against a queue model.
// Line-count expectations follow UART_RX_FIFO_LINE_EN exactly as the design does.
module tb_uart_rx_fifo;

    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ovf_clr;
    logic [AW:0] level;
    logic        overflow;
    logic [AW:0] line_cnt;
    logic        line_rdy;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.AW(AW), .EOL(8'h0A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .line_cnt (line_cnt),
        .line_rdy (line_rdy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: contents as a queue, sticky flag, last head value shown.
    byte unsigned model_q[$];
    byte unsigned popped[$];
    logic         model_ovf  = 1'b0;
    logic [7:0]   model_head = 8'h00;
    int           max_level  = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_lines();
        int n = 0;
`ifdef UART_RX_FIFO_LINE_EN
        foreach (model_q[i])
            if (model_q[i] == 8'h0A)
                n++;
`endif
        return n;
    endfunction

    task automatic check_all(input string tag);
        check_output({tag, ".level"},    32'(level),        32'(model_q.size()));
        check_output({tag, ".out_req"},  32'(bus.out_req),  32'(model_q.size() != 0));
        check_output({tag, ".overflow"}, 32'(overflow),     32'(model_ovf));
        check_output({tag, ".out_data"}, 32'(bus.out_data), 32'(model_head));
        check_output({tag, ".line_cnt"}, 32'(line_cnt),     32'(model_lines()));
        check_output({tag, ".line_rdy"}, 32'(line_rdy),     32'(model_lines() != 0));
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ovf  = 1'b0;
        model_head = 8'h00;
    endtask

    // One clock of stimulus, driven after a falling edge and checked at the next falling edge.
    task automatic apply_stimulus(input logic req, input logic [7:0] d, input logic ack,
                                  input logic clr, input string tag);
        logic do_pop;
        logic accept;
        bus.in_req  = req;
        bus.in_data = d;
        bus.out_ack = ack;
        ovf_clr     = clr;
        if (ack && bus.out_req)
            popped.push_back(bus.out_data);
        @(posedge clk);
        do_pop = ack && (model_q.size() != 0);
        accept = req && ((model_q.size() < DEPTH) || do_pop);
        if (do_pop)
            void'(model_q.pop_front());
        if (accept)
            model_q.push_back(d);
        if (req && !accept)
            model_ovf = 1'b1;
        else if (clr)
            model_ovf = 1'b0;
        if (model_q.size() != 0)
            model_head = model_q[0];
        if (model_q.size() > max_level)
            max_level = model_q.size();
        @(negedge clk);
        bus.in_req  = 1'b0;
        bus.out_ack = 1'b0;
        ovf_clr     = 1'b0;
        check_all(tag);
    endtask

    initial begin
        byte unsigned line_bytes[5];
        line_bytes = '{8'h41, 8'h42, 8'h0A, 8'h43, 8'h0A};

        rst_n       = 1'b0;
        bus.in_req  = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ack = 1'b0;
        ovf_clr     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("reset");

        // Burst fill to full, then one strobe that must be dropped.
        for (int i = 0; i < DEPTH; i++)
            apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0, "burst");
        check_output("burst_full_level", 32'(level), 32'(DEPTH));
        apply_stimulus(1'b1, 8'hFF, 1'b0, 1'b0, "burst_drop");
        check_output("burst_drop_ovf", 32'(overflow), 32'd1);

        // Clear alone, then clear coinciding with a drop (set must win), then clear again.
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, "clr_alone");
        apply_stimulus(1'b1, 8'hEE, 1'b0, 1'b1, "clr_vs_drop");
        check_output("clr_vs_drop_ovf", 32'(overflow), 32'd1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, "clr_again");

        // Strobe and pop together while full: byte kept, no overflow.
        popped.delete();
        apply_stimulus(1'b1, 8'h55, 1'b1, 1'b0, "full_simul");
        check_output("full_simul_level", 32'(level), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        check_output("drain_count", 32'(popped.size()), 32'(DEPTH + 1));
        for (int i = 0; i < DEPTH + 1 && i < popped.size(); i++)
            check_output("drain_order", 32'(popped[i]), (i < DEPTH) ? 32'(i) : 32'h55);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, "ack_empty");

        // Push/pop pairs with random gaps across two pointer wraps.
        popped.delete();
        max_level = 0;
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(1'b1, 8'(8'h10 + i), (model_q.size() != 0), 1'b0, "wrap");
            repeat ($urandom_range(0, 2))
                apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, "wrap_gap");
        end
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, "wrap_last");
        check_output("wrap_count", 32'(popped.size()), 32'd40);
        for (int i = 0; i < 40 && i < popped.size(); i++)
            check_output("wrap_order", 32'(popped[i]), 32'(8'h10 + i));
        check_output("wrap_max_level_le2", 32'(max_level <= 2), 32'd1);

        // Line detector: "AB\nC\n", drain three then two.
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b1, line_bytes[i], 1'b0, 1'b0, "line_push");
        repeat (3) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, "line_pop3");
        repeat (2) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, "line_pop2");

        // Random soak with line bytes mixed in; producer outruns consumer so it fills.
        for (int i = 0; i < 400; i++)
            apply_stimulus(($urandom_range(0, 99) < 55),
                           ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom),
                           ($urandom_range(0, 99) < 40),
                           ($urandom_range(0, 99) < 5), "soak");

        // Asynchronous reset mid-stream with five bytes stored.
        while (model_q.size() != 0)
            apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, "pre_rst_drain");
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "pre_rst_fill");
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b0, "post_rst");
        check_output("post_rst_data", 32'(bus.out_data), 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
